conv_encoder_framer: RTL

Rate-1/2, K=7 convolutional encoder with frame and tail generation. It sits directly upstream of `viterbi_decoder` and turns a framed stream of information bits into the 2-bit coded symbol stream that the decoder consumes on `d_in_valid`/`d_in`. Each frame is FRAME_LEN data bits followed by TAIL_LEN zero-input flush bits. This terminates the trellis and covers the decoder's traceback length.

---
 rtl/conv_encoder_framer.sv | 100 ++++++++++
 1 files changed

// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=7 convolutional encoder with frame sequencing.
// Each frame carries FRAME_LEN data bits followed by TAIL_LEN zero flush bits.
// The flush bits drive the trellis back to the all-zero state.
`timescale 1ns/1ps
module conv_encoder_framer #(
  parameter int             FRAME_LEN = 512,
  parameter int             TAIL_LEN  = 32,
  parameter int             K         = 7,
  parameter logic [K-1:0]   G0        = 7'b1111001,
  parameter logic [K-1:0]   G1        = 7'b1011011
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_data,
  output logic       d_out_valid,
  output logic [1:0] d_out,
  output logic       frame_done,
  output logic       busy
);

  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TW = (TAIL_LEN  > 1) ? $clog2(TAIL_LEN)  : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_LEN - 1);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t        state, state_nxt;
  logic [K-2:0]  sr;
  logic [BW-1:0] bit_cnt;
  logic [TW-1:0] tail_cnt;

  logic          accept, step, in_bit, last_bit, last_tail;
  logic [K-1:0]  w;
  logic [1:0]    sym;

  // Handshake and status depend on state only, so s_ready has no path from s_valid.
  assign s_ready   = (state == DATA);
  assign busy      = (state != IDLE);
  assign accept    = s_ready & s_valid;
  assign step      = accept | (state == TAIL);
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign last_tail = (tail_cnt == TAIL_LAST);

  // Encoder window: the current bit sits at the MSB and the oldest bit sits at bit 0.
  // Tail steps feed zeros into the window.
  assign in_bit = (state == DATA) ? s_data : 1'b0;
  assign w      = {in_bit, sr};
  assign sym    = {^(w & G0), ^(w & G1)};

  // State register
  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)               state_nxt = DATA;
      DATA:    if (accept && last_bit)  state_nxt = TAIL;
      TAIL:    if (last_tail)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Encoder shift register, counters, and registered symbol outputs
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sr          <= '0;
      bit_cnt     <= '0;
      tail_cnt    <= '0;
      d_out_valid <= 1'b0;
      d_out       <= 2'b00;
      frame_done  <= 1'b0;
    end else begin
      d_out_valid <= step;
      frame_done  <= (state == TAIL) && last_tail;
      if (state == IDLE && start) begin
        sr      <= '0;
        bit_cnt <= '0;
      end
      if (step) begin
        // d_out keeps its last value in cycles with no symbol.
        d_out <= sym;
        sr    <= w[K-1:1];
      end
      if (accept) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (last_bit) tail_cnt <= '0;
      end
      if (state == TAIL) tail_cnt <= tail_cnt + 1'b1;
    end
  end

endmodule
